// File: rtl/bounded_counter.sv
// Up/down counter confined to a runtime range [lo_bound, hi_bound], with wrap or
// saturate behaviour at the bounds, a terminal-count pulse and a sticky event flag.
module bounded_counter #(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              direction,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo_bound,
    input  logic [WIDTH-1:0]  hi_bound,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  counter_out,
    output logic              tc,
    output logic              ovf_sticky,
    output logic              at_lo,
    output logic              at_hi
);

    // One guard bit above the wider of count and step, so sums never truncate.
    localparam int EXT_W = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic [EXT_W-1:0] w_count_ext;
    logic [EXT_W-1:0] w_step_ext;
    logic [EXT_W-1:0] w_sum;
    logic [EXT_W-1:0] w_diff;
    logic [EXT_W-1:0] w_lo_plus_step;
    logic             w_up_fits;
    logic             w_dn_fits;
    logic             w_bounds_inv;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_next;
    logic             w_event;

    assign w_count_ext    = EXT_W'(r_count);
    assign w_step_ext     = EXT_W'(step);
    assign w_sum          = w_count_ext + w_step_ext;
    assign w_diff         = w_count_ext - w_step_ext;
    assign w_lo_plus_step = EXT_W'(lo_bound) + w_step_ext;
    assign w_up_fits      = (w_sum <= EXT_W'(hi_bound));
    assign w_dn_fits      = (w_count_ext >= w_lo_plus_step);
    assign w_bounds_inv   = (lo_bound > hi_bound);

    assign w_load_clamped = (load_val < lo_bound) ? lo_bound :
                            (load_val > hi_bound) ? hi_bound : load_val;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next  = r_count;
        w_event = 1'b0;
        if (load) begin
            w_next = w_bounds_inv ? lo_bound : w_load_clamped;
        end else if (enable) begin
            if (w_bounds_inv) begin
                w_next = lo_bound;
            end else if (step != '0) begin
                if (direction) begin
                    if (w_up_fits) begin
                        w_next = WIDTH'(w_sum);
                    end else begin
                        w_event = 1'b1;
                        w_next  = SATURATE ? hi_bound : lo_bound;
                    end
                end else begin
                    if (w_dn_fits) begin
                        w_next = WIDTH'(w_diff);
                    end else begin
                        w_event = 1'b1;
                        w_next  = SATURATE ? lo_bound : hi_bound;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_tc    <= w_event;
            // A boundary event outranks a coincident clear.
            if (w_event) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign counter_out = r_count;
    assign tc          = r_tc;
    assign ovf_sticky  = r_ovf;
    assign at_lo       = (r_count == lo_bound);
    assign at_hi       = (r_count == hi_bound);

endmodule

// File: tb/tb_bounded_counter.sv
// Bench for bounded_counter: a wrap-mode and a saturate-mode instance share stimulus
// and are compared every cycle against an integer-arithmetic reference model.
module tb_bounded_counter;

    logic       clk = 1'b0;
    logic       rst, enable, direction, load, clr_ovf;
    logic [7:0] load_val, lo_b, hi_b;
    logic [3:0] stp;

    logic [7:0] w_cnt, s_cnt;
    logic       w_tc, s_tc, w_ovf, s_ovf, w_alo, s_alo, w_ahi, s_ahi;

    int  vectors    = 0;
    int  miscompares = 0;
    bit  cmp_en     = 1'b0;

    int  m_cnt [2];
    bit  m_tc  [2];
    bit  m_ovf [2];

    always #5 clk = ~clk;

    bounded_counter #(.WIDTH(8), .STEP_W(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .enable(enable), .direction(direction), .load(load),
        .load_val(load_val), .step(stp), .lo_bound(lo_b), .hi_bound(hi_b),
        .clr_ovf(clr_ovf), .counter_out(w_cnt), .tc(w_tc), .ovf_sticky(w_ovf),
        .at_lo(w_alo), .at_hi(w_ahi)
    );

    bounded_counter #(.WIDTH(8), .STEP_W(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .enable(enable), .direction(direction), .load(load),
        .load_val(load_val), .step(stp), .lo_bound(lo_b), .hi_bound(hi_b),
        .clr_ovf(clr_ovf), .counter_out(s_cnt), .tc(s_tc), .ovf_sticky(s_ovf),
        .at_lo(s_alo), .at_hi(s_ahi)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 is wrap mode, index 1 is saturate mode.
    task automatic model_update();
        int lo, hi, lv, s;
        lo = int'(lo_b);
        hi = int'(hi_b);
        lv = int'(load_val);
        s  = int'(stp);
        for (int k = 0; k < 2; k++) begin
            int c;
            bit ev;
            c  = m_cnt[k];
            ev = 1'b0;
            if (rst) begin
                m_cnt[k] = 0;
                m_tc[k]  = 1'b0;
                m_ovf[k] = 1'b0;
            end else begin
                if (load || enable) begin
                    if (lo > hi)           c = lo;
                    else if (load)         c = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
                    else if (s != 0) begin
                        if (direction) begin
                            if (c + s <= hi) c = c + s;
                            else begin ev = 1'b1; c = (k == 1) ? hi : lo; end
                        end else begin
                            if (c - s >= lo) c = c - s;
                            else begin ev = 1'b1; c = (k == 1) ? lo : hi; end
                        end
                    end
                end
                m_cnt[k] = c;
                m_tc[k]  = ev;
                if (ev)           m_ovf[k] = 1'b1;
                else if (clr_ovf) m_ovf[k] = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("wrap_count", int'(w_cnt), m_cnt[0]);
            check("wrap_tc",    int'(w_tc),  int'(m_tc[0]));
            check("wrap_ovf",   int'(w_ovf), int'(m_ovf[0]));
            check("wrap_at_lo", int'(w_alo), int'(m_cnt[0] == int'(lo_b)));
            check("wrap_at_hi", int'(w_ahi), int'(m_cnt[0] == int'(hi_b)));
            check("sat_count",  int'(s_cnt), m_cnt[1]);
            check("sat_tc",     int'(s_tc),  int'(m_tc[1]));
            check("sat_ovf",    int'(s_ovf), int'(m_ovf[1]));
            check("sat_at_lo",  int'(s_alo), int'(m_cnt[1] == int'(lo_b)));
            check("sat_at_hi",  int'(s_ahi), int'(m_cnt[1] == int'(hi_b)));
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b1; direction = 1'b1; load = 1'b1; clr_ovf = 1'b0;
        load_val = 8'd99; lo_b = 8'd10; hi_b = 8'd20; stp = 4'd3;
        m_cnt = '{0, 0}; m_tc = '{0, 0}; m_ovf = '{0, 0};
        cyc(); cyc();
        check("reset_count", int'(w_cnt), 0);
        check("reset_tc",    int'(w_tc),  0);
        check("reset_ovf",   int'(s_ovf), 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Wrap up: 19 -> 10 (event) -> 13
        load = 1'b1; load_val = 8'd19; cyc();
        check("wrap_up_load", int'(w_cnt), 19);
        load = 1'b0; cyc();
        check("wrap_up_event_cnt", int'(w_cnt), 10);
        check("wrap_up_event_tc",  int'(w_tc), 1);
        check("sat_up_event_cnt",  int'(s_cnt), 20);
        cyc();
        check("wrap_up_after_cnt", int'(w_cnt), 13);
        check("wrap_up_after_tc",  int'(w_tc), 0);
        check("wrap_up_ovf",       int'(w_ovf), 1);

        // Wrap down: 12 -> 20 (event) -> 16
        stp = 4'd4; direction = 1'b0; load = 1'b1; load_val = 8'd12; cyc();
        check("wrap_dn_load", int'(w_cnt), 12);
        load = 1'b0; cyc();
        check("wrap_dn_event_cnt", int'(w_cnt), 20);
        check("wrap_dn_event_tc",  int'(w_tc), 1);
        cyc();
        check("wrap_dn_after_cnt", int'(w_cnt), 16);

        // Load beats enable and is clamped; then hold
        direction = 1'b1; load = 1'b1; load_val = 8'd30; cyc();
        check("load_clamp_cnt", int'(w_cnt), 20);
        check("load_clamp_tc",  int'(w_tc), 0);
        load = 1'b0; enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("hold_cnt", int'(w_cnt), 20);
        end

        // Zero step at the upper bound: no movement, no event
        enable = 1'b1; stp = 4'd0; cyc();
        check("step0_cnt", int'(w_cnt), 20);
        check("step0_tc",  int'(w_tc), 0);

        // Reset overrides load/enable/clr mid-count with the sticky flag set
        enable = 1'b0; load = 1'b1; load_val = 8'd15; cyc();
        check("pre_rst_ovf", int'(w_ovf), 1);
        rst = 1'b1; enable = 1'b1; load_val = 8'd19; clr_ovf = 1'b1; cyc();
        check("mid_rst_cnt", int'(w_cnt), 0);
        check("mid_rst_ovf", int'(w_ovf), 0);
        rst = 1'b0; clr_ovf = 1'b0; cyc();
        check("post_rst_load", int'(w_cnt), 19);

        // Event with simultaneous clear keeps the flag; a later clear drops it
        load = 1'b0; stp = 4'd3; clr_ovf = 1'b1; cyc();
        check("clr_on_event_tc",  int'(w_tc), 1);
        check("clr_on_event_ovf", int'(w_ovf), 1);
        stp = 4'd0; cyc();
        check("clr_ovf", int'(w_ovf), 0);
        clr_ovf = 1'b0;

        // Inverted bounds force the count to lo_bound
        lo_b = 8'd50; hi_b = 8'd40; stp = 4'd3; cyc();
        check("inv_bounds_cnt", int'(s_cnt), 50);
        check("inv_bounds_tc",  int'(s_tc), 0);

        // Saturate: 253 -> 255 x3 (events) -> 250
        lo_b = 8'd0; hi_b = 8'd255; stp = 4'd5; load = 1'b1; load_val = 8'd253; cyc();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("sat_hold_cnt", int'(s_cnt), 255);
            check("sat_hold_tc",  int'(s_tc), 1);
        end
        check("sat_at_hi_lit", int'(s_ahi), 1);
        direction = 1'b0; cyc();
        check("sat_back_cnt", int'(s_cnt), 250);
        check("sat_back_tc",  int'(s_tc), 0);

        // Plain wrapping counter: 254 -> 255 -> 0 (event) -> 1
        direction = 1'b1; stp = 4'd1; load = 1'b1; load_val = 8'd254; cyc();
        load = 1'b0; cyc();
        check("plain_255", int'(w_cnt), 255);
        cyc();
        check("plain_0",    int'(w_cnt), 0);
        check("plain_0_tc", int'(w_tc), 1);
        cyc();
        check("plain_1", int'(w_cnt), 1);

        // Randomized phase; bounds reshuffled periodically, occasionally inverted
        for (int n = 0; n < 3000; n++) begin
            if (n % 60 == 0) begin
                logic [7:0] a, b;
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                if ((a > b) != ($urandom_range(0, 7) == 0)) begin
                    lo_b = b; hi_b = a;
                end else begin
                    lo_b = a; hi_b = b;
                end
                if (n % 360 == 0) begin lo_b = 8'd0; hi_b = 8'd255; end
            end
            rst       = ($urandom_range(0, 99) == 0);
            load      = ($urandom_range(0, 9) == 0);
            enable    = ($urandom_range(0, 3) != 0);
            direction = 1'($urandom_range(0, 1));
            load_val  = 8'($urandom_range(0, 255));
            stp       = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            clr_ovf   = enable && !load && ($urandom_range(0, 7) == 0);
            cyc();
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bounded_counter.md
BOUNDED_COUNTER -- requirements
Module: bounded_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter STEP_W, default 4, giving the width of the step input.
REQ-003 The block SHALL have parameter SATURATE, default 0; 0 selects wrap mode, 1 selects saturate mode.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port enable, input, 1 bit: count enable; when low, the count holds.
REQ-007 The block SHALL have port direction, input, 1 bit: 1 counts up, 0 counts down.
REQ-008 The block SHALL have port load, input, 1 bit: synchronous load request.
REQ-009 The block SHALL have port load_val, input, WIDTH bits: the value to load.
REQ-010 The block SHALL have port step, input, STEP_W bits: the increment or decrement magnitude.
REQ-011 The block SHALL have ports lo_bound and hi_bound, inputs, WIDTH bits each: the inclusive count range.
REQ-012 The block SHALL have port clr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-013 The block SHALL have port counter_out, output, WIDTH bits, registered: the current count.
REQ-014 The block SHALL have port tc, output, 1 bit, registered: a terminal-count event pulse.
REQ-015 The block SHALL have port ovf_sticky, output, 1 bit, registered: the sticky boundary-event flag.
REQ-016 The block SHALL have ports at_lo and at_hi, outputs, 1 bit each, combinational: (counter_out==lo_bound) and (counter_out==hi_bound) respectively.

Function
REQ-017 Per-cycle priority SHALL be rst > load > enable > hold.
REQ-018 When load=1, counter_out SHALL take load_val clamped to [lo_bound, hi_bound], with no tc pulse and no ovf_sticky change, regardless of enable.
REQ-019 When enable=0 and load=0, counter_out, tc=0 and ovf_sticky SHALL hold.
REQ-020 All next-count arithmetic SHALL be performed at WIDTH+1 bits, with step zero-extended, so that no intermediate value silently truncates.
REQ-021 Up count: if counter_out+step <= hi_bound, next = counter_out+step; otherwise a boundary event occurs, and next = lo_bound (wrap mode) or hi_bound (saturate mode).
REQ-022 Down count: if counter_out >= lo_bound+step, next = counter_out-step; otherwise a boundary event occurs, and next = hi_bound (wrap mode) or lo_bound (saturate mode).
REQ-023 A wrap-mode boundary event SHALL land exactly on the opposite bound; there SHALL be no residue carry.
REQ-024 tc SHALL be 1 for exactly the cycle in which counter_out first shows the post-event value, and 0 otherwise.
REQ-025 In saturate mode, every further enabled cycle that pushes past the held bound SHALL be a boundary event (tc=1 each such cycle).
REQ-026 step=0 with enable=1 SHALL hold the count and SHALL NOT generate an event, even when the count sits at a bound.
REQ-027 A count left outside [lo_bound, hi_bound] by a runtime bound change SHALL be handled by the REQ-021/022 arithmetic unchanged (for example, an up-count from above hi_bound is an event).
REQ-028 If lo_bound > hi_bound, any enabled or load cycle SHALL set counter_out to lo_bound with tc=0 and no ovf_sticky change.
REQ-029 ovf_sticky SHALL be set on any cycle with a boundary event and cleared by clr_ovf; a simultaneous event and clr_ovf SHALL leave it set.
REQ-030 With lo_bound=0, hi_bound=all-ones, step=1 and SATURATE=0, behaviour SHALL equal a plain wrapping up/down counter.

Reset
REQ-031 On a clock edge with rst=1, counter_out SHALL become 0, and tc and ovf_sticky SHALL become 0, independent of bounds and all other inputs.
REQ-032 Reset asserted mid-count or on an event cycle SHALL override load, enable and clr_ovf; counting SHALL resume on the first edge after rst falls.

Verification
REQ-033 Wrap up: WIDTH=8, lo=10, hi=20, step=3, load 19, enable, direction=1 -> counter_out 19, 10, 13; tc=1 only on the 10 cycle; ovf_sticky=1.
REQ-034 Wrap down: lo=10, hi=20, step=4, load 12, direction=0 -> 12, 20, 16; tc pulses with the 20 value.
REQ-035 Saturate: SATURATE=1, lo=0, hi=255, step=5, load 253, direction=1 for 3 cycles -> 255, 255, 255 with tc=1 on each; at_hi=1; direction=0 -> 250, tc=0.
REQ-036 Priority: load=1 with load_val=30 (hi=20) together with enable=1 -> counter_out 20, tc=0; then enable=0 for 5 cycles -> holds at 20.
REQ-037 Reset: rst=1 for one cycle while counting at 15 with ovf_sticky=1 -> counter_out=0, tc=0, ovf_sticky=0 next cycle; clr_ovf on an event cycle keeps ovf_sticky=1.
REQ-038 Default mode: lo=0, hi=255, step=1, up from 254 -> 255, 0 (tc=1), 1; a random enable/direction sequence matches a reference model.
